// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the memory-mapped input port.
// Holds the default load addresses, the status-word bit positions,
// the response register layout and a helper that packs the status word.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_DATA_ADR   = 32'h8000_0068;
    localparam logic [31:0] DEFAULT_STATUS_ADR = 32'h8000_006C;

    localparam int STAT_UNDERFLOW = 31;
    localparam int STAT_FULL      = 5;
    localparam int STAT_EMPTY     = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rsp_t;

    // Only the low four bits of the occupancy fit below the flag bits;
    // a completely full 16-deep FIFO is identified by the full flag.
    function automatic logic [31:0] status_word(input logic       uf,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [3:0] cnt);
        logic [31:0] w;
        w                 = '0;
        w[3:0]            = cnt;
        w[STAT_EMPTY]     = empty;
        w[STAT_FULL]      = full;
        w[STAT_UNDERFLOW] = uf;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO storage with wrapping read/write pointers.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     write one word (caller guarantees !full)
//   pop             drop the head word (caller guarantees !empty)
//   rdata           current head word (combinational from storage)
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
module sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped input port: a producer streams words into a FIFO and the
// CPU drains them with loads. A load to DATA_ADR pops one word; a load to
// STATUS_ADR returns {underflow, full, empty, count} and clears underflow.
// Responses appear one cycle after the load strobe.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   MemoryAdr, ren       CPU load address and strobe
//   rd_data, rd_valid    registered load response
//   in_data, in_valid    producer word and offer
//   in_ready             FIFO can take a word this cycle
//   fifo_count           current occupancy
module mmio_input_port
    import mmio_pkg::*;
#(
    parameter  int          DEPTH      = 4,
    parameter  logic [31:0] DATA_ADR   = DEFAULT_DATA_ADR,
    parameter  logic [31:0] STATUS_ADR = DEFAULT_STATUS_ADR,
    localparam int          CW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   MemoryAdr,
    input  logic          ren,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [CW-1:0] fifo_count
);

    logic        data_hit;
    logic        status_hit;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [31:0] head;
    logic        underflow;
    rsp_t        rsp;

    assign data_hit   = ren && (MemoryAdr == DATA_ADR);
    assign status_hit = ren && (MemoryAdr == STATUS_ADR);

    // in_ready depends only on registered occupancy, so a pop in the same
    // cycle never opens the door for a push into a full FIFO.
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // No bypass: a data read while empty is an underflow even if a word
    // is being pushed on the same edge.
    assign pop      = data_hit && !empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp       <= '0;
            underflow <= 1'b0;
        end else begin
            rsp.valid <= data_hit || status_hit;
            if (data_hit)
                rsp.data <= empty ? 32'h0 : head;
            else if (status_hit)
                rsp.data <= status_word(underflow, full, empty, 4'(fifo_count));
            else
                rsp.data <= 32'h0;

            if (data_hit && empty) underflow <= 1'b1;
            else if (status_hit)   underflow <= 1'b0;
        end
    end

    assign rd_data  = rsp.data;
    assign rd_valid = rsp.valid;

endmodule

// File: tb/tb_mmio_input_port.sv
// Self-checking bench for mmio_input_port: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_mmio_input_port;

    localparam int          DEPTH = 4;
    localparam logic [31:0] DADR  = 32'h8000_0068;
    localparam logic [31:0] SADR  = 32'h8000_006C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] MemoryAdr = '0;
    logic        ren = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] q[$];
    bit          m_uf;
    bit          m_v;
    logic [31:0] m_d;

    always #5 clk = ~clk;

    mmio_input_port #(
        .DEPTH      (DEPTH),
        .DATA_ADR   (DADR),
        .STATUS_ADR (SADR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemoryAdr  (MemoryAdr),
        .ren        (ren),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the model, from the rules rather than the RTL.
    task automatic model_step(input bit r, input bit re, input logic [31:0] a,
                              input bit iv, input logic [31:0] d);
        int sz;
        if (r) begin
            q.delete();
            m_uf = 0;
            m_v  = 0;
            m_d  = 0;
            return;
        end
        sz  = q.size();
        m_v = 0;
        m_d = 0;
        if (re && a == DADR) begin
            m_v = 1;
            if (sz == 0) m_uf = 1;
            else         m_d = q.pop_front();
        end else if (re && a == SADR) begin
            m_v = 1;
            m_d = (m_uf ? 32'h8000_0000 : 32'h0)
                + (sz == DEPTH ? 32'h20 : 32'h0)
                + (sz == 0 ? 32'h10 : 32'h0)
                + 32'(sz % 16);
            m_uf = 0;
        end
        if (iv && sz != DEPTH) q.push_back(d);
    endtask

    task automatic cyc(input bit r, input bit re, input logic [31:0] a,
                       input bit iv, input logic [31:0] d);
        @(negedge clk);
        rst = r; ren = re; MemoryAdr = a; in_valid = iv; in_data = d;
        model_step(r, re, a, iv, d);
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(m_v));
        chk("rd_data", rd_data, m_d);
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 32'h0, 0, 32'h0);
        cyc(1, 0, 32'h0, 0, 32'h0);
        chk("reset_count", 32'(fifo_count), 32'h0);
        chk("reset_ready", 32'(in_ready), 32'h1);
        chk("reset_valid", 32'(rd_valid), 32'h0);

        // Push then pop on the next edge
        cyc(0, 0, 32'h0, 1, 32'hDEAD_BEEF);
        cyc(0, 1, DADR, 0, 32'h0);
        chk("first_pop_valid", 32'(rd_valid), 32'h1);
        chk("first_pop_data", rd_data, 32'hDEAD_BEEF);
        chk("first_pop_count", 32'(fifo_count), 32'h0);

        // Fill, status, overflow attempt, drain in order
        for (int i = 1; i <= 4; i++) cyc(0, 0, 32'h0, 1, 32'(i));
        chk("full_ready", 32'(in_ready), 32'h0);
        cyc(0, 1, SADR, 1, 32'h5);
        chk("full_status", rd_data, 32'h0000_0024);
        chk("full_count", 32'(fifo_count), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, DADR, 0, 32'h0);
            chk("drain_order", rd_data, 32'(i));
        end

        // Underflow and sticky clear
        cyc(0, 1, DADR, 0, 32'h0);
        chk("uf_valid", 32'(rd_valid), 32'h1);
        chk("uf_data", rd_data, 32'h0);
        cyc(0, 1, SADR, 0, 32'h0);
        chk("uf_status1", rd_data, 32'h8000_0010);
        cyc(0, 1, SADR, 0, 32'h0);
        chk("uf_status2", rd_data, 32'h0000_0010);

        // Push with simultaneous underflow read: word kept, no bypass
        cyc(0, 1, DADR, 1, 32'h77);
        chk("nobypass_data", rd_data, 32'h0);
        chk("nobypass_count", 32'(fifo_count), 32'h1);
        cyc(0, 1, DADR, 0, 32'h0);
        chk("nobypass_pop", rd_data, 32'h77);
        cyc(0, 1, SADR, 0, 32'h0);

        // Steady push+pop at count 2 across pointer wrap
        cyc(0, 0, 32'h0, 1, 32'd100);
        cyc(0, 0, 32'h0, 1, 32'd101);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, DADR, 1, 32'(102 + i));
            chk("wrap_data", rd_data, 32'(100 + i));
            chk("wrap_count", 32'(fifo_count), 32'h2);
        end

        // Unmapped address
        cyc(0, 1, 32'h8000_0064, 0, 32'h0);
        chk("other_valid", 32'(rd_valid), 32'h0);
        chk("other_data", rd_data, 32'h0);
        chk("other_count", 32'(fifo_count), 32'h2);

        // Reset coinciding with a data hit
        cyc(0, 0, 32'h0, 1, 32'h55);
        cyc(1, 1, DADR, 0, 32'h0);
        chk("rst_hit_valid", 32'(rd_valid), 32'h0);
        chk("rst_hit_count", 32'(fifo_count), 32'h0);
        chk("rst_hit_ready", 32'(in_ready), 32'h1);
        idle();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            bit          r, re, iv;
            logic [31:0] a;
            int          sel;
            r   = ($urandom_range(0, 99) == 0);
            re  = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            a   = (sel < 5) ? DADR : (sel < 8) ? SADR : $urandom;
            // Alternate phases bias towards filling or draining
            iv  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                       : ($urandom_range(0, 3) == 0);
            cyc(r, re, a, iv, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
